huff_tree_builder: RTL and testbench
====================================

HUFF_TREE_BUILDER -- requirements
Module: huff_tree_builder

Interface
REQ-001: Parameter NUM_SYM, default 128, number of leaf symbols (2..254).
REQ-002: Parameter FREQ_W, default 8, frequency/sum width.
REQ-003: Parameter DATA_W, default 8, memory data width (SHALL be at least FREQ_W and at least clog2(2*NUM_SYM)).
REQ-004: Parameter ADDR_W, default 16, memory address width.
REQ-005: Parameter FREQ_BASE, default 128, address of frequency of symbol 0.
REQ-006: Parameter NODE_BASE, default 256, address of node 0 word 0.
REQ-007: clk  in  1  single clock, rising edge.
REQ-008: n_rst  in  1  asynchronous, active-low reset.
REQ-009: start  in  1  one-cycle request to build a tree.
REQ-010: busy  out  1  high from the cycle after an accepted start until done.
REQ-011: done  out  1  one-cycle completion pulse.
REQ-012: err  out  2  status: 0 OK, 1 EMPTY, 2 OVERFLOW; held until next accepted start.
REQ-013: root_id  out  DATA_W  id of the tree root; held until next accepted start.
REQ-014: mem_addr  out  ADDR_W  memory address.
REQ-015: mem_R / mem_W  out  1 each  read / write strobes, never both high.
REQ-016: mem_data_W  out  DATA_W  write data.
REQ-017: mem_data_R  in  DATA_W  read data, valid the cycle after mem_R.

Function
REQ-018: Ids SHALL be: leaf s = s; node k = NUM_SYM+k; node k SHALL occupy NODE_BASE+3k (sum), +1 (child1 id), +2 (child2 id).
REQ-019: A zero value SHALL mean absent/consumed; only nonzero entries SHALL take part in the search.
REQ-020: States SHALL be IDLE, SCAN_RD, SCAN_CMP, EVAL, WR_SUM, WR_C1, WR_C2, CLR1, CLR2, FIN.
REQ-021: start SHALL be accepted only in IDLE; start while busy SHALL be ignored.
REQ-022: Each round SHALL scan leaves 0..NUM_SYM-1, then node sums 0..node_cnt-1, in that order, at 2 cycles per entry (SCAN_RD with mem_R=1, then SCAN_CMP).
REQ-023: The search SHALL track min1 (smallest) and min2 (second smallest); on equal values, the earlier-scanned entry SHALL rank lower.
REQ-024: In EVAL, 0 candidates in round 1 SHALL give err=EMPTY; 1 candidate SHALL give root_id = its id and err=OK; either case SHALL then go to FIN.
REQ-025: In EVAL, if min1+min2 exceeds 2^FREQ_W-1, err SHALL be OVERFLOW, with no write, then FIN.
REQ-026: Otherwise the block SHALL perform five 1-cycle writes in this order: sum, min1 id, min2 id, 0 to min1's address, 0 to min2's address.
REQ-027: After those writes, node_cnt SHALL increment and a new round SHALL start.
REQ-028: FIN SHALL pulse done for 1 cycle and return to IDLE.
REQ-029: node_cnt SHALL never exceed NUM_SYM-1; reaching that limit SHALL be impossible by construction and SHALL be asserted in simulation.
REQ-030: mem_data_W SHALL be zero-extended from FREQ_W when writing sums.
REQ-031: mem_addr, mem_R, mem_W and mem_data_W SHALL be registered outputs.

Reset
REQ-032: While n_rst=0, the block SHALL be in IDLE with busy=0, done=0, err=0, root_id=0, mem_R=0, mem_W=0, mem_addr=0, mem_data_W=0, node_cnt=0.
REQ-033: Reset asserted mid-operation SHALL abort immediately with no further memory strobes; memory contents are left as-is.

Structure
REQ-034: Package huff_pkg SHALL hold the err enum (HT_OK, HT_EMPTY, HT_OVF) and the state enum.
REQ-035: Sub-module huff_min2_tracker SHALL hold min1/min2 value, id and address, with clear, update-valid and candidate-count outputs.

Verification
REQ-036: Freq[0..5]=5,2,1,4,3,8, all others 0 -> the bench SHALL see nodes (3,2,1), (6,4,128), (9,3,0), (14,129,5), (23,130,131), then root_id=132, err=0, and all six leaves zeroed.
REQ-037: Only freq[7]=9 -> no writes, done, root_id=7, err=0.
REQ-038: All frequencies 0 -> done after 128 scan entries, err=1, no writes.
REQ-039: FREQ_W=8, freq[0]=200, freq[1]=100 -> err=2, no mem_W ever asserted.
REQ-040: start pulsed again during a scan -> ignored, and the result is identical to REQ-036.
REQ-041: n_rst low during WR_C1 of round 2 -> all outputs return to reset values; a new start with reloaded data then gives the REQ-036 result.

Source files
------------

// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared types for the Huffman tree builder
// Purpose: status codes and FSM state encoding used by huff_tree_builder.
// Ports: none (package).
package huff_pkg;

  typedef enum logic [1:0] {
    HT_OK    = 2'd0,
    HT_EMPTY = 2'd1,
    HT_OVF   = 2'd2
  } ht_err_e;

  typedef enum logic [3:0] {
    IDLE,
    SCAN_RD,
    SCAN_CMP,
    EVAL,
    WR_SUM,
    WR_C1,
    WR_C2,
    CLR1,
    CLR2,
    FIN
  } ht_state_e;

endpackage

// File: rtl/huff_min2_tracker.sv
// rtl/huff_min2_tracker.sv - running smallest / second-smallest tracker
// Purpose: keeps value, id and address of the two smallest candidates seen
//   since the last clear; ties keep the earlier candidate ranked lower.
// Ports:
//   clk, n_rst          clock, async active-low reset
//   i_clear             drop all candidates (start of a search round)
//   i_upd_valid         present candidate is live and must be ranked
//   i_val/i_id/i_addr   candidate value, id and memory address
//   o_min1_* / o_min2_* smallest / second smallest candidate
//   o_cand_cnt          candidates seen, saturating at 2
module huff_min2_tracker #(
  parameter int FREQ_W = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_clear,
  input  logic              i_upd_valid,
  input  logic [FREQ_W-1:0] i_val,
  input  logic [DATA_W-1:0] i_id,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [FREQ_W-1:0] o_min1_val,
  output logic [DATA_W-1:0] o_min1_id,
  output logic [ADDR_W-1:0] o_min1_addr,
  output logic [FREQ_W-1:0] o_min2_val,
  output logic [DATA_W-1:0] o_min2_id,
  output logic [ADDR_W-1:0] o_min2_addr,
  output logic [1:0]        o_cand_cnt
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_min1_val  <= '0;
      o_min1_id   <= '0;
      o_min1_addr <= '0;
      o_min2_val  <= '0;
      o_min2_id   <= '0;
      o_min2_addr <= '0;
      o_cand_cnt  <= 2'd0;
    end else if (i_clear) begin
      o_min1_val  <= '0;
      o_min1_id   <= '0;
      o_min1_addr <= '0;
      o_min2_val  <= '0;
      o_min2_id   <= '0;
      o_min2_addr <= '0;
      o_cand_cnt  <= 2'd0;
    end else if (i_upd_valid) begin
      // Strict less-than: an equal later candidate never displaces an earlier one.
      if (o_cand_cnt == 2'd0) begin
        o_min1_val  <= i_val;
        o_min1_id   <= i_id;
        o_min1_addr <= i_addr;
      end else if (i_val < o_min1_val) begin
        o_min2_val  <= o_min1_val;
        o_min2_id   <= o_min1_id;
        o_min2_addr <= o_min1_addr;
        o_min1_val  <= i_val;
        o_min1_id   <= i_id;
        o_min1_addr <= i_addr;
      end else if (o_cand_cnt == 2'd1 || i_val < o_min2_val) begin
        o_min2_val  <= i_val;
        o_min2_id   <= i_id;
        o_min2_addr <= i_addr;
      end
      if (o_cand_cnt != 2'd2) o_cand_cnt <= o_cand_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/huff_tree_builder.sv
// rtl/huff_tree_builder.sv - in-memory Huffman tree builder
// Purpose: repeatedly merges the two smallest nonzero leaf/node weights held
//   in memory into a new node until one root remains.
// Ports:
//   clk, n_rst           clock, async active-low reset
//   start                one-cycle build request (ignored while busy)
//   busy, done           running flag, one-cycle completion pulse
//   err, root_id         status (OK/EMPTY/OVERFLOW) and root id, held
//   mem_addr, mem_R/W    registered memory address and strobes
//   mem_data_W           registered write data
//   mem_data_R           read data, valid the cycle after mem_R
module huff_tree_builder
  import huff_pkg::*;
#(
  parameter int NUM_SYM   = 128,
  parameter int FREQ_W    = 8,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int FREQ_BASE = 128,
  parameter int NODE_BASE = 256
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] root_id,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_R,
  output logic              mem_W,
  output logic [DATA_W-1:0] mem_data_W,
  input  logic [DATA_W-1:0] mem_data_R
);

  ht_state_e         r_state;
  ht_err_e           r_err;
  logic              r_busy, r_done, r_mem_R, r_mem_W;
  logic [DATA_W-1:0] r_root_id, r_mem_data_W, r_node_cnt, r_idx;
  logic [ADDR_W-1:0] r_mem_addr;

  logic [FREQ_W-1:0] w_min1_val, w_min2_val;
  logic [DATA_W-1:0] w_min1_id, w_min2_id;
  logic [ADDR_W-1:0] w_min1_addr, w_min2_addr;
  logic [1:0]        w_cand_cnt;
  logic [FREQ_W-1:0] w_cand_val;
  logic              w_upd, w_clear, w_last;
  logic [FREQ_W:0]   w_sum;
  logic [DATA_W-1:0] w_new_id;

  // Scan index doubles as the entry id: leaves 0..NUM_SYM-1, then nodes.
  function automatic logic [ADDR_W-1:0] f_entry_addr(input logic [DATA_W-1:0] idx);
    if (idx < DATA_W'(NUM_SYM)) return ADDR_W'(FREQ_BASE) + ADDR_W'(idx);
    else return ADDR_W'(NODE_BASE) + ADDR_W'(3) * ADDR_W'(idx - DATA_W'(NUM_SYM));
  endfunction

  assign w_cand_val = mem_data_R[FREQ_W-1:0];
  assign w_upd      = (r_state == SCAN_CMP) && (w_cand_val != '0);
  assign w_clear    = ((r_state == IDLE) && start) || (r_state == CLR2);
  assign w_last     = (r_idx == DATA_W'(NUM_SYM - 1) + r_node_cnt);
  assign w_sum      = {1'b0, w_min1_val} + {1'b0, w_min2_val};
  assign w_new_id   = DATA_W'(NUM_SYM) + r_node_cnt;

  // r_mem_addr still holds the entry address during SCAN_CMP.
  huff_min2_tracker #(.FREQ_W(FREQ_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_tracker (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_clear    (w_clear),
    .i_upd_valid(w_upd),
    .i_val      (w_cand_val),
    .i_id       (r_idx),
    .i_addr     (r_mem_addr),
    .o_min1_val (w_min1_val),
    .o_min1_id  (w_min1_id),
    .o_min1_addr(w_min1_addr),
    .o_min2_val (w_min2_val),
    .o_min2_id  (w_min2_id),
    .o_min2_addr(w_min2_addr),
    .o_cand_cnt (w_cand_cnt)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_err        <= HT_OK;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_root_id    <= '0;
      r_mem_addr   <= '0;
      r_mem_R      <= 1'b0;
      r_mem_W      <= 1'b0;
      r_mem_data_W <= '0;
      r_node_cnt   <= '0;
      r_idx        <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_busy     <= 1'b1;
          r_err      <= HT_OK;
          r_root_id  <= '0;
          r_node_cnt <= '0;
          r_idx      <= '0;
          r_mem_addr <= ADDR_W'(FREQ_BASE);
          r_mem_R    <= 1'b1;
          r_state    <= SCAN_RD;
        end
        SCAN_RD: begin
          r_mem_R <= 1'b0;
          r_state <= SCAN_CMP;
        end
        SCAN_CMP: begin
          if (w_last) begin
            r_state <= EVAL;
          end else begin
            r_idx      <= r_idx + DATA_W'(1);
            r_mem_addr <= f_entry_addr(r_idx + DATA_W'(1));
            r_mem_R    <= 1'b1;
            r_state    <= SCAN_RD;
          end
        end
        EVAL: begin
          if (w_cand_cnt == 2'd0) begin
            // Only reachable in round 1: every merge leaves a nonzero sum behind.
            r_err   <= HT_EMPTY;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else if (w_cand_cnt == 2'd1) begin
            r_root_id <= w_min1_id;
            r_done    <= 1'b1;
            r_state   <= FIN;
          end else if (w_sum[FREQ_W]) begin
            r_err   <= HT_OVF;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_mem_W      <= 1'b1;
            r_mem_addr   <= f_entry_addr(w_new_id);
            r_mem_data_W <= DATA_W'(w_sum[FREQ_W-1:0]);
            r_state      <= WR_SUM;
          end
        end
        WR_SUM: begin
          r_mem_addr   <= r_mem_addr + ADDR_W'(1);
          r_mem_data_W <= w_min1_id;
          r_state      <= WR_C1;
        end
        WR_C1: begin
          r_mem_addr   <= r_mem_addr + ADDR_W'(1);
          r_mem_data_W <= w_min2_id;
          r_state      <= WR_C2;
        end
        WR_C2: begin
          r_mem_addr   <= w_min1_addr;
          r_mem_data_W <= '0;
          r_state      <= CLR1;
        end
        CLR1: begin
          r_mem_addr <= w_min2_addr;
          r_state    <= CLR2;
        end
        CLR2: begin
          r_mem_W    <= 1'b0;
          r_node_cnt <= r_node_cnt + DATA_W'(1);
          r_idx      <= '0;
          r_mem_addr <= ADDR_W'(FREQ_BASE);
          r_mem_R    <= 1'b1;
          r_state    <= SCAN_RD;
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NUM_SYM leaves can merge at most NUM_SYM-1 times.
  a_node_cnt_limit: assert property (@(posedge clk) disable iff (!n_rst)
    (r_node_cnt <= DATA_W'(NUM_SYM - 1)));

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign root_id    = r_root_id;
  assign mem_addr   = r_mem_addr;
  assign mem_R      = r_mem_R;
  assign mem_W      = r_mem_W;
  assign mem_data_W = r_mem_data_W;

endmodule

// File: tb/tb_huff_tree_builder.sv
// tb/tb_huff_tree_builder.sv - self-checking bench for huff_tree_builder
module tb_huff_tree_builder;

  logic        clk = 1'b0;
  logic        n_rst, start;
  logic        busy, done, mem_R, mem_W;
  logic [1:0]  err;
  logic [7:0]  root_id, mem_data_W, mem_data_R;
  logic [15:0] mem_addr;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:1023];
  int          freq [0:127];
  logic [23:0] dut_wr [$];
  logic [23:0] exp_wr [$];
  int          exp_err, exp_root, exp_cyc;
  int          run_cyc, run_nrd;
  bit          run_done, run_aborted, run_badbusy, run_both;

  huff_tree_builder dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .root_id   (root_id),
    .mem_addr  (mem_addr),
    .mem_R     (mem_R),
    .mem_W     (mem_W),
    .mem_data_W(mem_data_W),
    .mem_data_R(mem_data_R)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ent_addr(input int id);
    return (id < 128) ? (128 + id) : (256 + 3 * (id - 128));
  endfunction

  // Reference: each round picks the two smallest live weights (lowest id wins
  // ties), writes a node, retires both children; cycles follow the round cost.
  task automatic ref_model();
    int v [0:255];
    int nc, i1, i2, sum, ent;
    bit fin;
    nc = 0; fin = 0;
    exp_wr.delete(); exp_err = 0; exp_root = 0; exp_cyc = 0;
    for (int i = 0; i < 256; i++) v[i] = (i < 128) ? freq[i] : 0;
    while (!fin) begin
      ent = 128 + nc;
      i1 = -1;
      for (int i = 0; i < ent; i++) if (v[i] != 0 && (i1 < 0 || v[i] < v[i1])) i1 = i;
      i2 = -1;
      for (int i = 0; i < ent; i++) if (i != i1 && v[i] != 0 && (i2 < 0 || v[i] < v[i2])) i2 = i;
      exp_cyc += 2 * ent + 1;
      if (i1 < 0) begin
        exp_err = 1; fin = 1;
      end else if (i2 < 0) begin
        exp_root = i1; fin = 1;
      end else if (v[i1] + v[i2] > 255) begin
        exp_err = 2; fin = 1;
      end else begin
        sum = v[i1] + v[i2];
        exp_wr.push_back({16'(ent_addr(ent)), 8'(sum)});
        exp_wr.push_back({16'(ent_addr(ent) + 1), 8'(i1)});
        exp_wr.push_back({16'(ent_addr(ent) + 2), 8'(i2)});
        exp_wr.push_back({16'(ent_addr(i1)), 8'd0});
        exp_wr.push_back({16'(ent_addr(i2)), 8'd0});
        v[ent] = sum; v[i1] = 0; v[i2] = 0;
        nc++;
        exp_cyc += 5;
      end
    end
  endtask

  task automatic load_mem();
    for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
    for (int s = 0; s < 128; s++) mem[128 + s] = 8'(freq[s]);
  endtask

  task automatic set_req036();
    for (int s = 0; s < 128; s++) freq[s] = 0;
    freq[0] = 5; freq[1] = 2; freq[2] = 1; freq[3] = 4; freq[4] = 3; freq[5] = 8;
  endtask

  // Pulses start, then services the memory bus every cycle until done.
  task automatic run_build(input int start_again_at, input int abort_write);
    bit        rd_pending;
    logic [15:0] rd_addr;
    dut_wr.delete();
    run_nrd = 0; run_done = 0; run_aborted = 0; run_badbusy = 0; run_both = 0;
    rd_pending = 0; rd_addr = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_cyc = 0;
    while (run_cyc < 40000) begin
      if (rd_pending) mem_data_R = mem[rd_addr[9:0]];
      rd_pending = 0;
      if (mem_R && mem_W) run_both = 1;
      if (!busy) run_badbusy = 1;
      if (mem_R) begin
        rd_pending = 1; rd_addr = mem_addr; run_nrd++;
      end
      if (mem_W) begin
        dut_wr.push_back({mem_addr, mem_data_W});
        if (abort_write != 0 && dut_wr.size() == abort_write) begin
          n_rst = 1'b0; run_aborted = 1;
          break;
        end
        mem[mem_addr[9:0]] = mem_data_W;
      end
      start = (start_again_at > 0 && run_cyc == start_again_at);
      if (done) begin
        run_done = 1;
        break;
      end
      @(posedge clk); #1;
      run_cyc++;
    end
    start = 1'b0;
    if (!run_aborted) chk("done_timeout", 32'(run_done), 1);
  endtask

  task automatic check_run(input string tag);
    int nbad;
    nbad = 0;
    chk({tag, " cycles"}, run_cyc, exp_cyc);
    chk({tag, " busy_during"}, 32'(run_badbusy), 0);
    chk({tag, " r_and_w"}, 32'(run_both), 0);
    chk({tag, " err"}, 32'(err), exp_err);
    chk({tag, " root"}, 32'(root_id), exp_root);
    chk({tag, " nwrites"}, dut_wr.size(), exp_wr.size());
    for (int i = 0; i < dut_wr.size() && i < exp_wr.size(); i++)
      if (dut_wr[i] !== exp_wr[i]) nbad++;
    chk({tag, " write_list"}, nbad, 0);
    @(posedge clk); #1;
    chk({tag, " busy_after"}, 32'(busy), 0);
    chk({tag, " done_after"}, 32'(done), 0);
    chk({tag, " err_held"}, 32'(err), exp_err);
    chk({tag, " root_held"}, 32'(root_id), exp_root);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " err"}, 32'(err), 0);
    chk({tag, " root"}, 32'(root_id), 0);
    chk({tag, " mem_R"}, 32'(mem_R), 0);
    chk({tag, " mem_W"}, 32'(mem_W), 0);
    chk({tag, " addr"}, 32'(mem_addr), 0);
    chk({tag, " wdata"}, 32'(mem_data_W), 0);
  endtask

  task automatic check_req036_consts(input string tag);
    int exp_nodes [0:14];
    int idx;
    exp_nodes = '{3, 2, 1, 6, 4, 128, 9, 3, 0, 14, 129, 5, 23, 130, 131};
    for (int k = 0; k < 15; k++) begin
      idx = 5 * (k / 3) + (k % 3);
      chk($sformatf("%s node_word%0d", tag, k),
          (idx < dut_wr.size()) ? 32'(dut_wr[idx][7:0]) : 32'hFFFF_FFFF, exp_nodes[k]);
    end
    chk({tag, " root_const"}, 32'(root_id), 132);
    for (int s = 0; s < 6; s++) chk($sformatf("%s leaf%0d_zero", tag, s), 32'(mem[128 + s]), 0);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; mem_data_R = 8'd0;
    for (int s = 0; s < 128; s++) freq[s] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Six-leaf reference tree
    set_req036(); load_mem(); ref_model();
    run_build(0, 0);
    check_run("t036");
    check_req036_consts("t036");

    // Single nonzero leaf
    for (int s = 0; s < 128; s++) freq[s] = 0;
    freq[7] = 9;
    load_mem(); ref_model();
    run_build(0, 0);
    check_run("t037");
    chk("t037 root_const", 32'(root_id), 7);

    // All zero
    for (int s = 0; s < 128; s++) freq[s] = 0;
    load_mem(); ref_model();
    run_build(0, 0);
    chk("t038 reads", run_nrd, 128);
    check_run("t038");
    chk("t038 err_const", 32'(err), 1);

    // Overflow on first merge
    for (int s = 0; s < 128; s++) freq[s] = 0;
    freq[0] = 200; freq[1] = 100;
    load_mem(); ref_model();
    run_build(0, 0);
    check_run("t039");
    chk("t039 err_const", 32'(err), 2);

    // Second start during scan is ignored
    set_req036(); load_mem(); ref_model();
    run_build(20, 0);
    check_run("t040");
    check_req036_consts("t040");

    // Reset during WR_C1 of round 2 (7th write), then rebuild
    set_req036(); load_mem(); ref_model();
    run_build(0, 7);
    chk("t041 aborted", 32'(run_aborted), 1);
    #1;
    check_reset_outputs("t041 mid_reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("t041 held_reset");
    n_rst = 1'b1;
    @(posedge clk); #1;
    load_mem();
    run_build(0, 0);
    check_run("t041");
    check_req036_consts("t041");

    // Random sparse frequency sets, some overflowing mid-tree
    for (int r = 0; r < 6; r++) begin
      int k;
      for (int s = 0; s < 128; s++) freq[s] = 0;
      k = $urandom_range(2, 10);
      for (int j = 0; j < k; j++) freq[$urandom_range(0, 127)] = $urandom_range(1, 60);
      load_mem(); ref_model();
      run_build(0, 0);
      check_run($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
